// File: rtl/approx_prod_accum.sv
// rtl/approx_prod_accum.sv - saturating burst accumulator for approximate 4-bit products
module approx_prod_accum #(
  parameter int ACC_W = 12,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_p,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [LEN_W-1:0] out_count,
  output logic             out_sat,
  output logic             out_trunc
);

  typedef enum logic {ST_ACC, ST_DONE} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             trunc_q, trunc_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [LEN_W-1:0] out_count_q, out_count_d;
  logic             out_sat_q, out_sat_d;
  logic             out_trunc_q, out_trunc_d;

  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] acc_new;
  logic [LEN_W-1:0] cnt_inc;
  logic             term_max;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    trunc_d     = trunc_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_sat_d   = out_sat_q;
    out_trunc_d = out_trunc_q;

    // acc never exceeds all-ones and in_p <= 15, so the carry bit alone flags overflow
    sum_ext  = {1'b0, acc_q} + {{(ACC_W-3){1'b0}}, in_p};
    acc_new  = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
    cnt_inc  = cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};
    term_max = (cnt_inc == {LEN_W{1'b1}});

    if (state_q == ST_ACC) begin
      if (in_valid) begin
        acc_d = acc_new;
        cnt_d = cnt_inc;
        sat_d = sat_q | sum_ext[ACC_W];
        if (in_last || term_max) begin
          trunc_d     = trunc_q | (term_max & ~in_last);
          state_d     = ST_DONE;
          out_sum_d   = acc_new;
          out_count_d = cnt_inc;
          out_sat_d   = sat_q | sum_ext[ACC_W];
          out_trunc_d = trunc_q | (term_max & ~in_last);
        end
      end
    end else begin
      if (out_ready) begin
        acc_d   = '0;
        cnt_d   = '0;
        sat_d   = 1'b0;
        trunc_d = 1'b0;
        state_d = ST_ACC;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      trunc_q     <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
      out_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      trunc_q     <= trunc_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_sat_q   <= out_sat_d;
      out_trunc_q <= out_trunc_d;
    end
  end

  // Handshake outputs decode only the state flop, so out_ready never reaches in_ready
  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_DONE);
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_sat   = out_sat_q;
  assign out_trunc = out_trunc_q;

endmodule

// File: tb/tb_approx_prod_accum.sv
// tb/tb_approx_prod_accum.sv - scoreboard bench for approx_prod_accum (ACC_W=12 and ACC_W=5 side by side)
module tb_approx_prod_accum;

  localparam int MAXLEN = 15;
  localparam int MAX12  = 4095;
  localparam int MAX5   = 31;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_p;
  logic        in_last;
  logic        out_ready;
  logic        in_ready_a, in_ready_b;
  logic        out_valid_a, out_valid_b;
  logic [11:0] out_sum_a;
  logic [4:0]  out_sum_b;
  logic [3:0]  out_count_a, out_count_b;
  logic        out_sat_a, out_sat_b;
  logic        out_trunc_a, out_trunc_b;

  always #5 clk = ~clk;

  approx_prod_accum #(.ACC_W(12), .LEN_W(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_p(in_p), .in_last(in_last), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_sum(out_sum_a), .out_count(out_count_a), .out_sat(out_sat_a), .out_trunc(out_trunc_a)
  );

  approx_prod_accum #(.ACC_W(5), .LEN_W(4)) u_dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_p(in_p), .in_last(in_last), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_sum(out_sum_b), .out_count(out_count_b), .out_sat(out_sat_b), .out_trunc(out_trunc_b)
  );

  typedef struct {
    int sum12;
    int sat12;
    int sum5;
    int sat5;
    int cnt;
    int trunc;
    int end_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   rdy_mode = 0;
  int   burst_total = 0;
  int   burst_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a burst's saturating sum is just min(total, max) since all addends are non-negative
  task automatic model_beat(input int p, input bit last);
    exp_t e;
    burst_total += p;
    burst_n++;
    if (last || burst_n == MAXLEN) begin
      e.sum12   = (burst_total > MAX12) ? MAX12 : burst_total;
      e.sat12   = (burst_total > MAX12) ? 1 : 0;
      e.sum5    = (burst_total > MAX5) ? MAX5 : burst_total;
      e.sat5    = (burst_total > MAX5) ? 1 : 0;
      e.cnt     = burst_n;
      e.trunc   = last ? 0 : 1;
      e.end_cyc = cyc + 1;
      exp_q.push_back(e);
      burst_total = 0;
      burst_n     = 0;
    end
  endtask

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 2) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic send(input int p, input bit last);
    int w = 0;
    @(posedge clk); #2;
    in_valid = 1'b1;
    in_p     = 4'(p);
    in_last  = last;
    while (!in_ready_a && w < 60) begin
      @(posedge clk); #2;
      w++;
    end
    if (!in_ready_a) begin
      check("send_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      model_beat(p, last);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #2;
      in_valid = 1'b0;
      in_p     = 4'($urandom);
      in_last  = 1'($urandom);
    end
  endtask

  task automatic drain();
    int w = 0;
    idle(1);
    while ((exp_q.size() != 0 || out_valid_a) && w < 300) begin
      @(posedge clk);
      w++;
    end
    #2;
    check("drain_done", (exp_q.size() == 0 && !out_valid_a) ? 1 : 0, 1);
  endtask

  // Monitor: pops the expected result on the first valid cycle and watches it stay put until handoff
  bit          seen = 1'b0;
  logic [11:0] h_sum_a;
  logic [4:0]  h_sum_b;
  logic [3:0]  h_cnt;
  logic        h_sat_a, h_sat_b, h_trunc;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("ready_vs_valid", int'(in_ready_a), int'(!out_valid_a));
      check("valid_w5_match", int'(out_valid_b), int'(out_valid_a));
      if (out_valid_a) begin
        if (!seen) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("out_sum", int'(out_sum_a), e.sum12);
            check("out_sat", int'(out_sat_a), e.sat12);
            check("out_sum_w5", int'(out_sum_b), e.sum5);
            check("out_sat_w5", int'(out_sat_b), e.sat5);
            check("out_count", int'(out_count_a), e.cnt);
            check("out_count_w5", int'(out_count_b), e.cnt);
            check("out_trunc", int'(out_trunc_a), e.trunc);
            check("out_trunc_w5", int'(out_trunc_b), e.trunc);
            check("latency", cyc, e.end_cyc);
          end
          seen    = 1'b1;
          h_sum_a = out_sum_a;
          h_sum_b = out_sum_b;
          h_cnt   = out_count_a;
          h_sat_a = out_sat_a;
          h_sat_b = out_sat_b;
          h_trunc = out_trunc_a;
        end else begin
          check("hold_sum", int'(out_sum_a), int'(h_sum_a));
          check("hold_sum_w5", int'(out_sum_b), int'(h_sum_b));
          check("hold_count", int'(out_count_a), int'(h_cnt));
          check("hold_sat", int'(out_sat_a), int'(h_sat_a));
          check("hold_sat_w5", int'(out_sat_b), int'(h_sat_b));
          check("hold_trunc", int'(out_trunc_a), int'(h_trunc));
        end
        if (out_ready) seen = 1'b0;
      end else begin
        seen = 1'b0;
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, int'(in_ready_a), 1);
    check({tag, "_out_valid"}, int'(out_valid_a), 0);
    check({tag, "_out_sum"}, int'(out_sum_a), 0);
    check({tag, "_out_sum_w5"}, int'(out_sum_b), 0);
    check({tag, "_out_count"}, int'(out_count_a), 0);
    check({tag, "_out_sat"}, int'(out_sat_b), 0);
    check({tag, "_out_trunc"}, int'(out_trunc_a), 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_p      = 4'd0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check_reset_values("reset");
    rst = 1'b0;

    send(3, 0); send(5, 0); send(7, 1);
    drain();

    for (int i = 0; i < MAXLEN; i++) send(15, 0);
    drain();

    send(15, 0); send(15, 0); send(15, 1);
    drain();

    rdy_mode = 2;
    send(9, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      check("hold_out_valid", int'(out_valid_a), 1);
      check("hold_in_ready", int'(in_ready_a), 0);
      check("hold_sum9", int'(out_sum_a), 9);
      in_valid = i[0];
      in_p     = 4'd5;
      in_last  = 1'b1;
    end
    rdy_mode = 0;
    idle(1);
    send(2, 0); send(2, 1);
    drain();

    send(4, 0); send(4, 0);
    @(posedge clk); #3;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_values("async_reset");
    burst_total = 0;
    burst_n     = 0;
    #3;
    rst = 1'b0;
    send(1, 0); send(1, 1);
    drain();

    rdy_mode = 1;
    for (int b = 0; b < 200; b++) begin
      int len;
      len = $urandom_range(1, 17);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        send($urandom_range(0, 15), (i == len - 1));
      end
    end
    drain();
    rdy_mode = 0;

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
